// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register carrying NUM_DATA data words, a register-file write
// address and a control vector between two stages. It has a valid/ready
// handshake, an optional skid entry (SKID=1) that keeps o_ready registered,
// and a synchronous flush. Control bits are gated to zero on bubbles.
module pipe_stage_buffer #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_DATA = 2,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned CTRL_W   = 2,
   parameter int unsigned SKID     = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [NUM_DATA*DATA_W-1:0] i_data,
   input  logic [ADDR_W-1:0]          i_wr_addr,
   input  logic [CTRL_W-1:0]          i_ctrl,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [NUM_DATA*DATA_W-1:0] o_data,
   output logic [ADDR_W-1:0]          o_wr_addr,
   output logic [CTRL_W-1:0]          o_ctrl
);

   localparam int unsigned DW = NUM_DATA * DATA_W;
   // Packed payload: {data, wr_addr, ctrl}
   localparam int unsigned PW = DW + ADDR_W + CTRL_W;

   logic [PW-1:0] in_pld;
   logic          main_valid_q, main_valid_d;
   logic [PW-1:0] main_pld_q, main_pld_d;
   logic          ready;

   assign in_pld = {i_data, i_wr_addr, i_ctrl};

   generate
      if (SKID != 0) begin : g_skid
         logic          skid_valid_q, skid_valid_d;
         logic [PW-1:0] skid_pld_q, skid_pld_d;

         // Next-state for main and skid entries; flush wins over every transfer
         always_comb begin
            main_valid_d = main_valid_q;
            main_pld_d   = main_pld_q;
            skid_valid_d = skid_valid_q;
            skid_pld_d   = skid_pld_q;
            if (i_flush) begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end else if (skid_valid_q) begin
               // Upstream is stalled here; only drain skid into main
               if (i_ready) begin
                  main_pld_d   = skid_pld_q;
                  skid_valid_d = 1'b0;
               end
            end else if (main_valid_q) begin
               if (i_ready) begin
                  main_valid_d = i_valid;
                  if (i_valid) begin
                     main_pld_d = in_pld;
                  end
               end else if (i_valid) begin
                  skid_valid_d = 1'b1;
                  skid_pld_d   = in_pld;
               end
            end else if (i_valid) begin
               main_valid_d = 1'b1;
               main_pld_d   = in_pld;
            end
         end

         // Skid entry state
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_valid_q <= 1'b0;
               skid_pld_q   <= '0;
            end else begin
               skid_valid_q <= skid_valid_d;
               skid_pld_q   <= skid_pld_d;
            end
         end

         // Ready depends only on a flop, so no combinational path from i_ready
         assign ready = ~skid_valid_q;
      end else begin : g_noskid
         logic load;

         assign ready = i_ready | ~main_valid_q;
         assign load  = i_valid & ready;

         // Single-entry next-state; flush discards the incoming entry
         always_comb begin
            main_valid_d = main_valid_q;
            main_pld_d   = main_pld_q;
            if (i_flush) begin
               main_valid_d = 1'b0;
            end else if (load) begin
               main_valid_d = 1'b1;
               main_pld_d   = in_pld;
            end else if (i_ready) begin
               main_valid_d = 1'b0;
            end
         end
      end
   endgenerate

   // Main entry state; payload is only cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_pld_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_pld_q   <= main_pld_d;
      end
   end

   assign o_ready   = ready;
   assign o_valid   = main_valid_q;
   assign o_data    = main_pld_q[PW-1 -: DW];
   assign o_wr_addr = main_pld_q[CTRL_W +: ADDR_W];
   // Bubbles must never assert write enables downstream
   assign o_ctrl    = main_pld_q[CTRL_W-1:0] & {CTRL_W{main_valid_q}};

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed table vectors, hand sequences and a random scoreboard run for
// pipe_stage_buffer in both skid and single-entry configurations.
module tb_pipe_stage_buffer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // u0: SKID=1, default widths
   logic        i0_flush, i0_valid, i0_ready, o0_ready, o0_valid;
   logic [63:0] i0_data, o0_data;
   logic [4:0]  i0_addr, o0_addr;
   logic [1:0]  i0_ctrl, o0_ctrl;

   // u1: SKID=0, NUM_DATA=3, DATA_W=16
   logic        i1_flush, i1_valid, i1_ready, o1_ready, o1_valid;
   logic [47:0] i1_data, o1_data;
   logic [4:0]  i1_addr, o1_addr;
   logic [1:0]  i1_ctrl, o1_ctrl;

   pipe_stage_buffer #(
      .DATA_W(32), .NUM_DATA(2), .ADDR_W(5), .CTRL_W(2), .SKID(1)
   ) u0 (
      .clk(clk), .rst(rst), .i_flush(i0_flush), .i_valid(i0_valid), .o_ready(o0_ready),
      .i_data(i0_data), .i_wr_addr(i0_addr), .i_ctrl(i0_ctrl), .o_valid(o0_valid),
      .i_ready(i0_ready), .o_data(o0_data), .o_wr_addr(o0_addr), .o_ctrl(o0_ctrl)
   );

   pipe_stage_buffer #(
      .DATA_W(16), .NUM_DATA(3), .ADDR_W(5), .CTRL_W(2), .SKID(0)
   ) u1 (
      .clk(clk), .rst(rst), .i_flush(i1_flush), .i_valid(i1_valid), .o_ready(o1_ready),
      .i_data(i1_data), .i_wr_addr(i1_addr), .i_ctrl(i1_ctrl), .o_valid(o1_valid),
      .i_ready(i1_ready), .o_data(o1_data), .o_wr_addr(o1_addr), .o_ctrl(o1_ctrl)
   );

   typedef struct {
      logic        flush;
      logic        valid;
      logic        ready;
      logic [31:0] d;
      logic [1:0]  c;
      logic        ev;
      logic        erdy;
      logic [31:0] ed;
      logic [1:0]  ec;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;
   logic [70:0] sb[$];

   task automatic add(input logic f, input logic v, input logic r, input logic [31:0] d,
                      input logic [1:0] c, input logic ev, input logic erdy,
                      input logic [31:0] ed, input logic [1:0] ec);
      vec_t x;
      x.flush = f; x.valid = v; x.ready = r; x.d = d; x.c = c;
      x.ev = ev; x.erdy = erdy; x.ed = ed; x.ec = ec;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Word1 is derived from word0 so both words get checked
   function automatic logic [63:0] wide(input logic [31:0] d);
      return {d ^ 32'hFFFF_0000, d};
   endfunction

   initial begin
      rst = 1'b1;
      i0_flush = 1'b0; i0_valid = 1'b0; i0_ready = 1'b0; i0_data = '0; i0_addr = '0;
      i0_ctrl = '0;
      i1_flush = 1'b0; i1_valid = 1'b0; i1_ready = 1'b0; i1_data = '0; i1_addr = '0;
      i1_ctrl = '0;

      //   fl    v     r     d         c      ov    rdy   od        oc
      add(1'b0, 1'b1, 1'b1, 32'h11, 2'd3, 1'b1, 1'b1, 32'h11, 2'd3);
      add(1'b0, 1'b1, 1'b1, 32'h22, 2'd3, 1'b1, 1'b1, 32'h22, 2'd3);
      add(1'b0, 1'b1, 1'b1, 32'h33, 2'd3, 1'b1, 1'b1, 32'h33, 2'd3);
      add(1'b0, 1'b0, 1'b1, 32'h00, 2'd0, 1'b0, 1'b1, 32'h33, 2'd0);
      // backpressure into skid, source holds C while o_ready=0
      add(1'b0, 1'b1, 1'b0, 32'h0A, 2'd1, 1'b1, 1'b1, 32'h0A, 2'd1);
      add(1'b0, 1'b1, 1'b0, 32'h0B, 2'd2, 1'b1, 1'b0, 32'h0A, 2'd1);
      add(1'b0, 1'b1, 1'b0, 32'h0C, 2'd3, 1'b1, 1'b0, 32'h0A, 2'd1);
      add(1'b0, 1'b1, 1'b1, 32'h0C, 2'd3, 1'b1, 1'b1, 32'h0B, 2'd2);
      add(1'b0, 1'b1, 1'b1, 32'h0C, 2'd3, 1'b1, 1'b1, 32'h0C, 2'd3);
      add(1'b0, 1'b0, 1'b1, 32'h00, 2'd0, 1'b0, 1'b1, 32'h0C, 2'd0);
      // flush in skid state with an incoming entry
      add(1'b0, 1'b1, 1'b0, 32'h05, 2'd1, 1'b1, 1'b1, 32'h05, 2'd1);
      add(1'b0, 1'b1, 1'b0, 32'h06, 2'd1, 1'b1, 1'b0, 32'h05, 2'd1);
      add(1'b1, 1'b1, 1'b0, 32'h07, 2'd2, 1'b0, 1'b1, 32'h05, 2'd0);
      add(1'b0, 1'b0, 1'b1, 32'h00, 2'd0, 1'b0, 1'b1, 32'h05, 2'd0);
      // flush with a concurrent downstream transfer
      add(1'b0, 1'b1, 1'b1, 32'h44, 2'd1, 1'b1, 1'b1, 32'h44, 2'd1);
      add(1'b1, 1'b1, 1'b1, 32'h55, 2'd3, 1'b0, 1'b1, 32'h44, 2'd0);
      add(1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1, 32'h44, 2'd0);
      // full, idle hold
      add(1'b0, 1'b1, 1'b0, 32'h66, 2'd2, 1'b1, 1'b1, 32'h66, 2'd2);
      add(1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 1'b1, 32'h66, 2'd2);
      add(1'b0, 1'b0, 1'b1, 32'h00, 2'd0, 1'b0, 1'b1, 32'h66, 2'd0);

      // reset state, checked while reset is still asserted
      #2;
      chk("rst_ov0", 64'(o0_valid), 64'd0);
      chk("rst_rdy0", 64'(o0_ready), 64'd1);
      chk("rst_od0", o0_data, 64'd0);
      chk("rst_oa0", 64'(o0_addr), 64'd0);
      chk("rst_oc0", 64'(o0_ctrl), 64'd0);
      chk("rst_ov1", 64'(o1_valid), 64'd0);
      chk("rst_rdy1", 64'(o1_ready), 64'd1);
      chk("rst_od1", 64'(o1_data), 64'd0);
      #10 rst = 1'b0;

      foreach (vecs[i]) begin
         i0_flush = vecs[i].flush;
         i0_valid = vecs[i].valid;
         i0_ready = vecs[i].ready;
         i0_data  = wide(vecs[i].d);
         i0_addr  = vecs[i].d[4:0];
         i0_ctrl  = vecs[i].c;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ov", i), 64'(o0_valid), 64'(vecs[i].ev));
         chk($sformatf("v%0d_rdy", i), 64'(o0_ready), 64'(vecs[i].erdy));
         chk($sformatf("v%0d_od", i), o0_data, wide(vecs[i].ed));
         chk($sformatf("v%0d_oa", i), 64'(o0_addr), 64'(vecs[i].ed[4:0]));
         chk($sformatf("v%0d_oc", i), 64'(o0_ctrl), 64'(vecs[i].ec));
      end

      // async reset between edges while holding a valid entry
      i0_flush = 1'b0; i0_valid = 1'b1; i0_ready = 1'b0;
      i0_data = wide(32'h99); i0_addr = 5'h19; i0_ctrl = 2'b10;
      @(posedge clk);
      #1;
      i0_valid = 1'b0;
      chk("ar_pre_ov", 64'(o0_valid), 64'd1);
      chk("ar_pre_oc", 64'(o0_ctrl), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("ar_ov", 64'(o0_valid), 64'd0);
      chk("ar_oc", 64'(o0_ctrl), 64'd0);
      chk("ar_od", o0_data, 64'd0);
      chk("ar_oa", 64'(o0_addr), 64'd0);
      chk("ar_rdy", 64'(o0_ready), 64'd1);
      #1 rst = 1'b0;
      i0_valid = 1'b1; i0_ready = 1'b1; i0_data = wide(32'h77); i0_addr = 5'h17;
      i0_ctrl = 2'b01;
      @(posedge clk);
      #1;
      chk("ar_resume_ov", 64'(o0_valid), 64'd1);
      chk("ar_resume_od", o0_data, wide(32'h77));
      i0_valid = 1'b0;
      @(posedge clk);
      #1;

      // SKID=0: combinational ready, three 16-bit words
      i1_valid = 1'b1; i1_ready = 1'b0;
      i1_data = {16'hBEEF, 16'h1234, 16'h5678}; i1_addr = 5'h1A; i1_ctrl = 2'b01;
      @(posedge clk);
      #1;
      chk("s0_ov", 64'(o1_valid), 64'd1);
      chk("s0_rdy_stall", 64'(o1_ready), 64'd0);
      chk("s0_word2", 64'(o1_data[47:32]), 64'hBEEF);
      chk("s0_word0", 64'(o1_data[15:0]), 64'h5678);
      chk("s0_oa", 64'(o1_addr), 64'h1A);
      chk("s0_oc", 64'(o1_ctrl), 64'd1);
      i1_ready = 1'b1;
      #1;
      chk("s0_rdy_comb", 64'(o1_ready), 64'd1);
      i1_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("s0_drain_ov", 64'(o1_valid), 64'd0);
      chk("s0_drain_oc", 64'(o1_ctrl), 64'd0);
      chk("s0_hold_word2", 64'(o1_data[47:32]), 64'hBEEF);
      i1_valid = 1'b1; i1_data = {16'hCAFE, 16'h0001, 16'h0002}; i1_ctrl = 2'b11;
      @(posedge clk);
      #1;
      chk("s0_load_ov", 64'(o1_valid), 64'd1);
      i1_flush = 1'b1; i1_data = {16'hDEAD, 16'h0003, 16'h0004};
      @(posedge clk);
      #1;
      chk("s0_flush_ov", 64'(o1_valid), 64'd0);
      chk("s0_flush_word2", 64'(o1_data[47:32]), 64'hCAFE);
      i1_flush = 1'b0; i1_valid = 1'b0;

      // random valid/ready/flush against a FIFO scoreboard on the skid instance
      sb.delete();
      for (int cyc = 0; cyc < 1010; cyc++) begin
         @(negedge clk);
         if (cyc < 1000) begin
            i0_valid = ($urandom_range(99) < 70);
            i0_ready = ($urandom_range(99) < 60);
            i0_flush = ($urandom_range(99) < 2);
            i0_data  = {$urandom, $urandom};
            i0_addr  = 5'($urandom_range(31));
            i0_ctrl  = 2'($urandom_range(3));
         end else begin
            i0_valid = 1'b0; i0_ready = 1'b1; i0_flush = 1'b0;
         end
         #4;
         if (!o0_valid) begin
            chk("rnd_bubble_ctrl", 64'(o0_ctrl), 64'd0);
         end
         if (o0_valid && i0_ready) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL rnd_extra got=%h want=none at %0t", o0_data, $time);
            end else begin
               logic [70:0] exp_p;
               exp_p = sb.pop_front();
               total++;
               if ({o0_data, o0_addr, o0_ctrl} !== exp_p) begin
                  bad++;
                  $display("FAIL rnd_order got=%h want=%h at %0t",
                           {o0_data, o0_addr, o0_ctrl}, exp_p, $time);
               end
            end
         end
         if (i0_flush) begin
            sb.delete();
         end else if (i0_valid && o0_ready) begin
            sb.push_back({i0_data, i0_addr, i0_ctrl});
         end
         @(posedge clk);
      end
      chk("rnd_lost", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised pipeline-stage register that supersedes the fixed-field stage buffers. It carries NUM_DATA data words, one register-file write address and CTRL_W control bits between two pipeline stages. It adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, and bubble gating of control bits. It is instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with field widths set per stage.

Parameters:
DATA_W, 32, width of each data word
NUM_DATA, 2, number of data words carried (e.g. ALU result, RAM data)
ADDR_W, 5, width of register-file write address
CTRL_W, 2, width of control vector (e.g. {regWrite, memToReg})
SKID, 1, 1 = registered o_ready with skid entry; 0 = single entry, combinational ready

Ports:
clk  input  1  stage clock, rising edge
rst  input  1  asynchronous, active-high reset
i_flush  input  1  synchronous flush; kills held and incoming entries
i_valid  input  1  upstream entry valid
o_ready  output  1  buffer can accept an upstream entry
i_data  input  NUM_DATA*DATA_W  data words, word k at bits [k*DATA_W +: DATA_W]
i_wr_addr  input  ADDR_W  register-file write address
i_ctrl  input  CTRL_W  control vector
o_valid  output  1  downstream entry valid
i_ready  input  1  downstream stage accepts entry
o_data  output  NUM_DATA*DATA_W  held data words
o_wr_addr  output  ADDR_W  held write address
o_ctrl  output  CTRL_W  held control, forced 0 when o_valid=0

Behaviour:
- Transfers: upstream on i_valid&o_ready at a clk edge; downstream on o_valid&i_ready at a clk edge.
- Reset (rst=1, async): main and skid valid = 0; all data/addr/ctrl registers = 0. Outputs: o_valid=0, o_data=0, o_wr_addr=0, o_ctrl=0, o_ready=1 (both SKID modes).
- Latency: 1 cycle from upstream accept to o_valid when the buffer is empty.
- Throughput: 1 entry per cycle while i_ready=1.
- o_ctrl = ctrl_reg AND o_valid (bitwise replicated). A bubble never asserts regWrite/memWrite downstream.
- o_data and o_wr_addr hold their last value when invalid. They are not cleared except by reset.
- SKID=1, states:
  - EMPTY (main invalid): o_ready=1. On i_valid: load main -> FULL.
  - FULL (main valid, skid invalid): o_ready=1.
    - i_ready&i_valid: main<=input, stay FULL.
    - i_ready&!i_valid -> EMPTY.
    - !i_ready&i_valid: skid<=input -> SKID.
    - !i_ready&!i_valid: hold.
  - SKID (both valid): o_ready=0.
    - i_ready: main<=skid, skid invalid -> FULL.
    - Otherwise hold.
  - o_ready is registered and equals NOT skid_valid. Entries are never dropped or duplicated.
  - FIFO order is preserved: the skid entry always exits after the main entry.
- SKID=0: no skid entry. o_ready = i_ready OR NOT o_valid (combinational).
  - Main loads on i_valid&o_ready.
  - Main goes invalid when it is consumed and nothing is loaded.
- Flush (i_flush=1 at a clk edge) has the highest priority over all transfers:
  - Main valid and skid valid become 0; state -> EMPTY.
  - An upstream entry handshaked in the same cycle is discarded.
  - A downstream transfer in the same cycle still completes: downstream sampled it.
  - Data registers are unchanged.
- Reset asserted mid-operation: immediate async clear as listed above. Operation resumes on the first edge after rst deasserts.
- Widths: no arithmetic; all fields pass bit-exact.

Test Plan:
- Reset then stream: rst pulse; send 0x11,0x22,0x33 (word0) with i_ready=1, ctrl=2'b11 -> o_valid rises 1 cycle after each accept; outputs 0x11,0x22,0x33 in consecutive cycles; o_ctrl=2'b11 only while o_valid=1.
- Backpressure, SKID=1: main holds 0xA, i_ready=0, input 0xB -> skid takes 0xB, o_ready=0 next cycle; input 0xC held by source; i_ready=1 -> outputs 0xA,0xB,0xC in order, none lost or duplicated.
- Flush in SKID state: main=0x5, skid=0x6, i_flush=1 with i_valid=1 data 0x7 -> next cycle o_valid=0, o_ctrl=0, o_ready=1; 0x5, 0x6 and 0x7 never appear downstream.
- SKID=0 instance, NUM_DATA=3, DATA_W=16: i_ready=0 while full -> o_ready=0 in the same cycle; i_ready=1 -> o_ready=1 combinationally; word2 0xBEEF arrives at bits [47:32].
- Async reset mid-stream: assert rst between clk edges while o_valid=1, o_ctrl=2'b10 -> o_valid=0, o_ctrl=0, o_data=0 immediately, without waiting for a clk edge.
- Random valid/ready, 1000 cycles, flush 2% -> scoreboard: output sequence equals the input sequence minus flushed entries; o_ctrl=0 whenever o_valid=0.
